// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: RAW/load-use hazard detection, EXE forwarding selects and long-latency register scoreboard.
module hazard_scoreboard_unit #(
  parameter int REG_AW  = 4,
  parameter int LAT_W   = 3,
  parameter int FWD_EN  = 1,
  parameter int STALL_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_AW-1:0]     id_rn,
  input  logic [REG_AW-1:0]     id_rm,
  input  logic [REG_AW-1:0]     id_rs,
  input  logic                  id_use_rn,
  input  logic                  id_use_rm,
  input  logic                  id_use_rs,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_read,
  input  logic [REG_AW-1:0]     exe_dest,
  input  logic                  mem_wb_en,
  input  logic [REG_AW-1:0]     mem_dest,
  input  logic                  mc_issue,
  input  logic [REG_AW-1:0]     mc_dest,
  input  logic [LAT_W-1:0]      mc_lat,
  input  logic                  flush,
  output logic                  freeze,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic [1:0]            fwd_sel_s,
  output logic [(1<<REG_AW)-1:0] sb_busy,
  output logic [STALL_W-1:0]    stall_cnt
);
  localparam int NR = 1 << REG_AW;
  logic [NR-1:0][LAT_W-1:0] cnt;
  logic [2:0] use_v, exe_m, mem_m, sb_m;
  logic [REG_AW-1:0] src [3];
  logic [1:0] nxt [3];
  logic raw, waw, bubble, accept;
  logic [LAT_W-1:0] lat_ld;
  assign use_v = {id_use_rs, id_use_rm, id_use_rn};
  assign src[0] = id_rn;
  assign src[1] = id_rm;
  assign src[2] = id_rs;
  for (genvar r = 0; r < NR; r++) begin : g_busy
    assign sb_busy[r] = cnt[r] != '0;
  end
  for (genvar s = 0; s < 3; s++) begin : g_src
    assign exe_m[s] = use_v[s] && (src[s] == exe_dest);
    assign mem_m[s] = use_v[s] && (src[s] == mem_dest);
    assign sb_m[s]  = use_v[s] && sb_busy[src[s]];
    // EXE producer is the youngest, so it wins over MEM
    assign nxt[s] = (bubble || FWD_EN == 0) ? 2'b00 :
                    (exe_wb_en && !exe_mem_read && exe_m[s]) ? 2'b01 :
                    (mem_wb_en && mem_m[s]) ? 2'b10 : 2'b00;
  end
  assign raw = (FWD_EN != 0) ? (exe_wb_en && exe_mem_read && |exe_m)
                             : ((exe_wb_en && |exe_m) || (mem_wb_en && |mem_m));
  assign waw    = mc_issue && sb_busy[mc_dest];
  assign freeze = id_valid && !flush && (raw || |sb_m || waw);
  assign bubble = flush || freeze || !id_valid;
  assign accept = mc_issue && id_valid && !freeze && !flush;
  assign lat_ld = (mc_lat == '0) ? LAT_W'(1) : mc_lat;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_sel_a <= 2'b00;
      fwd_sel_b <= 2'b00;
      fwd_sel_s <= 2'b00;
    end else begin
      fwd_sel_a <= nxt[0];
      fwd_sel_b <= nxt[1];
      fwd_sel_s <= nxt[2];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else
      for (int r = 0; r < NR; r++)
        if (accept && mc_dest == REG_AW'(r)) cnt[r] <= lat_ld;
        else if (cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (freeze && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit: directed table plus multi-cycle sequences on a forwarding and a non-forwarding instance.
module tb_hazard_scoreboard_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic id_valid, id_use_rn, id_use_rm, id_use_rs, exe_wb_en, exe_mem_read, mem_wb_en, mc_issue, flush;
  logic [3:0] id_rn, id_rm, id_rs, exe_dest, mem_dest, mc_dest;
  logic [2:0] mc_lat;
  logic freeze1, freeze0;
  logic [1:0] fa1, fb1, fs1, fa0, fb0, fs0;
  logic [15:0] sb1, sb0, sc1;
  logic [3:0] sc0;
  int nchk = 0, nerr = 0;

  hazard_scoreboard_unit #(.REG_AW(4), .LAT_W(3), .FWD_EN(1), .STALL_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm), .id_rs(id_rs),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rs(id_use_rs), .exe_wb_en(exe_wb_en),
    .exe_mem_read(exe_mem_read), .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .mc_issue(mc_issue), .mc_dest(mc_dest), .mc_lat(mc_lat), .flush(flush), .freeze(freeze1),
    .fwd_sel_a(fa1), .fwd_sel_b(fb1), .fwd_sel_s(fs1), .sb_busy(sb1), .stall_cnt(sc1));

  hazard_scoreboard_unit #(.REG_AW(4), .LAT_W(3), .FWD_EN(0), .STALL_W(4)) u0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm), .id_rs(id_rs),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rs(id_use_rs), .exe_wb_en(exe_wb_en),
    .exe_mem_read(exe_mem_read), .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .mc_issue(mc_issue), .mc_dest(mc_dest), .mc_lat(mc_lat), .flush(flush), .freeze(freeze0),
    .fwd_sel_a(fa0), .fwd_sel_b(fb0), .fwd_sel_s(fs0), .sb_busy(sb0), .stall_cnt(sc0));

  typedef struct {
    string nm;
    logic v;
    logic [3:0] rn, rm, rs;
    logic [2:0] u;
    logic ew, el;
    logic [3:0] ed;
    logic mw;
    logic [3:0] md;
    logic fl, z1, z0;
    logic [1:0] a, b, s;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(string nm, logic v, logic [3:0] rn, rm, rs, logic [2:0] u, logic ew, el,
                              logic [3:0] ed, logic mw, logic [3:0] md, logic fl, z1, z0, logic [1:0] a, b, s);
    vec_t t;
    t.nm = nm; t.v = v; t.rn = rn; t.rm = rm; t.rs = rs; t.u = u; t.ew = ew; t.el = el; t.ed = ed;
    t.mw = mw; t.md = md; t.fl = fl; t.z1 = z1; t.z0 = z0; t.a = a; t.b = b; t.s = s;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rn = 0; id_rm = 0; id_rs = 0; id_use_rn = 0; id_use_rm = 0; id_use_rs = 0;
    exe_wb_en = 0; exe_mem_read = 0; exe_dest = 0; mem_wb_en = 0; mem_dest = 0;
    mc_issue = 0; mc_dest = 0; mc_lat = 0; flush = 0;
  endtask

  task automatic apply(input vec_t t);
    id_valid = t.v; id_rn = t.rn; id_rm = t.rm; id_rs = t.rs;
    {id_use_rs, id_use_rm, id_use_rn} = t.u;
    exe_wb_en = t.ew; exe_mem_read = t.el; exe_dest = t.ed;
    mem_wb_en = t.mw; mem_dest = t.md; flush = t.fl; mc_issue = 0;
  endtask

  initial begin
    int e1, e0;
    //              name       v  rn  rm  rs  use    ew el ed mw md  fl z1 z0  a      b      s
    tbl[0] = mk("exe_fwd",   1, 3,  0,  0,  3'b001, 1, 0, 3, 0, 0,  0, 0, 1, 2'b01, 2'b00, 2'b00);
    tbl[1] = mk("mem_fwd",   1, 3,  0,  0,  3'b001, 0, 0, 3, 1, 3,  0, 0, 1, 2'b10, 2'b00, 2'b00);
    tbl[2] = mk("no_prod",   1, 3,  0,  0,  3'b001, 0, 0, 3, 0, 3,  0, 0, 0, 2'b00, 2'b00, 2'b00);
    tbl[3] = mk("rm_exe",    1, 0,  5,  0,  3'b010, 1, 0, 5, 0, 0,  0, 0, 1, 2'b00, 2'b01, 2'b00);
    tbl[4] = mk("rm_load",   1, 0,  5,  0,  3'b010, 1, 1, 5, 0, 0,  0, 1, 1, 2'b00, 2'b00, 2'b00);
    tbl[5] = mk("exe_prio",  1, 7,  0,  7,  3'b001, 1, 0, 7, 1, 7,  0, 0, 1, 2'b01, 2'b00, 2'b00);
    tbl[6] = mk("rs_mem",    1, 0,  0,  2,  3'b100, 1, 0, 9, 1, 2,  0, 0, 1, 2'b00, 2'b00, 2'b10);
    tbl[7] = mk("flush",     1, 3,  0,  0,  3'b001, 1, 1, 3, 0, 0,  1, 0, 0, 2'b00, 2'b00, 2'b00);
    tbl[8] = mk("invalid",   0, 3,  0,  0,  3'b001, 1, 0, 3, 0, 0,  0, 0, 0, 2'b00, 2'b00, 2'b00);
    tbl[9] = mk("r15",       1, 15, 0,  0,  3'b001, 0, 0, 0, 1, 15, 0, 0, 1, 2'b10, 2'b00, 2'b00);
    idle();
    #2;
    chk("rst_freeze1", freeze1, 0); chk("rst_freeze0", freeze0, 0);
    chk("rst_fwd1", {fa1, fb1, fs1}, 0); chk("rst_busy1", sb1, 0);
    chk("rst_sc1", sc1, 0); chk("rst_sc0", sc0, 0);
    @(negedge clk) rst_n = 1;
    e1 = 0; e0 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) apply(tbl[i]);
      #1;
      chk({tbl[i].nm, "_freeze1"}, freeze1, tbl[i].z1);
      chk({tbl[i].nm, "_freeze0"}, freeze0, tbl[i].z0);
      @(posedge clk) #1;
      e1 += int'(tbl[i].z1);
      if (tbl[i].z0 && e0 < 15) e0++;
      chk({tbl[i].nm, "_fa"}, fa1, tbl[i].a);
      chk({tbl[i].nm, "_fb"}, fb1, tbl[i].b);
      chk({tbl[i].nm, "_fs"}, fs1, tbl[i].s);
      chk({tbl[i].nm, "_fwd0"}, {fa0, fb0, fs0}, 0);
      chk({tbl[i].nm, "_sc1"}, sc1, e1);
      chk({tbl[i].nm, "_sc0"}, sc0, e0);
    end
    // long-latency issue to r4, then a reader of r4 stalls 3 cycles
    @(negedge clk) idle();
    id_valid = 1; mc_issue = 1; mc_dest = 4; mc_lat = 3;
    @(negedge clk) mc_issue = 0; id_use_rn = 1; id_rn = 4;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("sb_freeze", freeze1, i < 3);
      chk("sb_busy4", sb1[4], i < 3);
      @(negedge clk);
    end
    idle();
    id_valid = 1; mc_issue = 1; mc_dest = 6; mc_lat = 0;
    @(negedge clk) mc_issue = 0;
    #1 chk("lat0_busy", sb1[6], 1);
    @(negedge clk) #1 chk("lat0_done", sb1[6], 0);
    @(negedge clk) idle();
    id_valid = 1; mc_issue = 1; mc_dest = 4; mc_lat = 3;
    @(negedge clk) mc_lat = 7;
    #1 chk("waw_freeze", freeze1, 1);
    @(negedge clk) mc_issue = 0;
    #1 chk("waw_busy_a", sb1[4], 1);
    @(negedge clk) #1 chk("waw_busy_b", sb1[4], 1);
    @(negedge clk) #1 chk("waw_noreload", sb1[4], 0);
    // flush with RAW, scoreboard hit and an issue all present
    @(negedge clk) idle();
    id_valid = 1; mc_issue = 1; mc_dest = 2; mc_lat = 4;
    id_use_rn = 1; id_rn = 3; exe_wb_en = 1; exe_dest = 3;
    @(negedge clk) flush = 1; exe_mem_read = 1; id_use_rm = 1; id_rm = 2; mc_dest = 5; mc_lat = 3;
    #1;
    chk("fl_prime_fa", fa1, 2'b01);
    chk("fl_freeze1", freeze1, 0);
    chk("fl_freeze0", freeze0, 0);
    @(posedge clk) #1;
    chk("fl_fa", fa1, 2'b00);
    chk("fl_noissue", sb1[5], 0);
    @(negedge clk) idle();
    for (int i = 0; i < 4; i++) begin
      #1 chk("fl_busy2", sb1[2], i < 3);
      @(negedge clk);
    end
    // async reset with r1 mid-countdown
    idle();
    id_valid = 1; mc_issue = 1; mc_dest = 1; mc_lat = 4;
    @(negedge clk) mc_issue = 0; id_use_rn = 1; id_rn = 3; exe_wb_en = 1; exe_dest = 3;
    @(negedge clk);
    @(negedge clk) #1;
    chk("pre_rst_busy1", sb1[1], 1);
    chk("pre_rst_fa", fa1, 2'b01);
    #1 rst_n = 0;
    #1;
    chk("arst_busy", sb1, 0);
    chk("arst_fa", fa1, 0);
    chk("arst_sc1", sc1, 0);
    chk("arst_sc0", sc0, 0);
    @(negedge clk) rst_n = 1; idle();
    // stall-counter saturation on the 4-bit instance
    @(negedge clk) id_valid = 1; id_use_rn = 1; id_rn = 3; exe_wb_en = 1; exe_mem_read = 1; exe_dest = 3;
    repeat (15) @(posedge clk);
    #1;
    chk("sat15_sc0", sc0, 15);
    chk("sat15_sc1", sc1, 15);
    repeat (6) @(posedge clk);
    #1;
    chk("sat_sc0", sc0, 15);
    chk("sat_sc1", sc1, 21);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
